// File: rtl/concat_stream.sv
// Narrow-to-wide stream assembler: packs CONCAT_NUM beats of DATAW_IN bits into one
// DATAW_OUT word, with valid/ready on both sides, selectable lane order and partial-word flush.
module concat_stream #(
  parameter int DATAW_IN   = 8,
  parameter int DATAW_OUT  = 32,
  parameter int CONCAT_NUM = 4,
  parameter int CNT_W      = $clog2(CONCAT_NUM + 1),
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATAW_IN-1:0]  din,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [DATAW_OUT-1:0] dout,
  output logic [CNT_W-1:0]     out_lanes,
  output logic                 out_last,
  input  logic                 out_ready
);

  if (DATAW_OUT != DATAW_IN * CONCAT_NUM) begin : g_width_check
    $error("concat_stream: DATAW_OUT must equal DATAW_IN*CONCAT_NUM");
  end
  if (CONCAT_NUM < 2) begin : g_num_check
    $error("concat_stream: CONCAT_NUM must be >= 2");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONCAT_NUM - 1);

  logic [DATAW_OUT-1:0] acc;
  logic [DATAW_OUT-1:0] accMerged;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     laneIdx;
  logic [CNT_W-1:0]     effLanes;
  logic                 slotFree;
  logic                 accIn;
  logic                 complete;
  logic                 doFlush;
  logic                 loadOut;

  // Only the closing beat of a word has to wait for the output slot.
  always_comb begin
    slotFree = !out_valid || out_ready;
    in_ready = !((cnt == LAST_CNT) && !slotFree);
    accIn    = in_valid && in_ready;
    laneIdx  = MSB_FIRST ? (LAST_CNT - cnt) : cnt;
    effLanes = cnt + CNT_W'(accIn);
    complete = accIn && (cnt == LAST_CNT);
    doFlush  = flush && slotFree && (effLanes != '0);
    loadOut  = complete || doFlush;
  end

  // Accumulator view including this cycle's beat, so completion and flush can emit it directly.
  always_comb begin
    accMerged = acc;
    if (accIn) begin
      accMerged[laneIdx*DATAW_IN +: DATAW_IN] = din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (loadOut) begin
      acc <= '0;
      cnt <= '0;
    end else if (accIn) begin
      acc <= accMerged;
      cnt <= cnt + 1'b1;
    end
  end

  // Output register: a load in the same cycle as a drain keeps out_valid high (no bubble).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_lanes <= '0;
      out_last  <= 1'b0;
    end else if (loadOut) begin
      out_valid <= 1'b1;
      dout      <= accMerged;
      out_lanes <= effLanes;
      out_last  <= flush;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
